// File: rtl/bp_be_late_wb_arbiter_if.sv
// bp_be_late_wb_arbiter_if: source/scheduler bundle for the late-writeback arbiter.
interface bp_be_late_wb_arbiter_if #(
    parameter int num_src_p   = 3,
    parameter int pkt_width_p = 80,
    parameter int cnt_width_p = 16
);
    localparam int id_width_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;
    logic [num_src_p*pkt_width_p-1:0] src_pkt_i;
    logic [num_src_p-1:0]             src_v_i;
    logic [num_src_p-1:0]             src_ready_and_o;
    logic [pkt_width_p-1:0]           late_wb_pkt_o;
    logic                             late_wb_v_o;
    logic                             late_wb_force_o;
    logic                             late_wb_yumi_i;
    logic [id_width_lp-1:0]           grant_id_o;
    logic                             busy_o;
    logic [cnt_width_p-1:0]           stat_wb_cnt_o;
    logic [cnt_width_p-1:0]           stat_force_cnt_o;
    modport master (
        output src_pkt_i, src_v_i, late_wb_yumi_i,
        input  src_ready_and_o, late_wb_pkt_o, late_wb_v_o, late_wb_force_o,
               grant_id_o, busy_o, stat_wb_cnt_o, stat_force_cnt_o
    );
    modport slave (
        input  src_pkt_i, src_v_i, late_wb_yumi_i,
        output src_ready_and_o, late_wb_pkt_o, late_wb_v_o, late_wb_force_o,
               grant_id_o, busy_o, stat_wb_cnt_o, stat_force_cnt_o
    );
endinterface

// File: rtl/bp_be_late_wb_arbiter.sv
// bp_be_late_wb_arbiter: one-entry buffers per long-latency source, round-robin onto one late-wb port.
// Optional statistics counters enabled by BP_BE_LATE_WB_STATS_EN.
module bp_be_late_wb_arbiter #(
    parameter int num_src_p      = 3,
    parameter int pkt_width_p    = 80,
    parameter int starve_limit_p = 16,
    parameter int cnt_width_p    = 16
) (
    input logic clk_i,
    input logic reset_n_i,
    bp_be_late_wb_arbiter_if.slave io
);
    localparam int id_w_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;
    localparam int wc_w_lp = $clog2(starve_limit_p + 1);
    localparam logic [id_w_lp:0]   n_lp    = (id_w_lp + 1)'(num_src_p);
    localparam logic [id_w_lp-1:0] last_lp = id_w_lp'(num_src_p - 1);
    localparam logic [wc_w_lp-1:0] lim_lp  = wc_w_lp'(starve_limit_p);

    logic [num_src_p-1:0]   r_buf_v;
    logic [pkt_width_p-1:0] r_buf_pkt [num_src_p];
    logic [id_w_lp-1:0]     r_rr_ptr, r_locked_id;
    logic                   r_lock;
    logic [wc_w_lp-1:0]     r_wait_cnt;

    logic                 w_v, w_yumi;
    logic [num_src_p-1:0] w_rot, w_ready, w_load, w_drain;
    logic [id_w_lp-1:0]   w_off, w_grant;
    logic [id_w_lp:0]     w_sum;

    // Rotate valids so bit 0 is rr_ptr; lowest set bit is the round-robin winner.
    always_comb begin
        w_rot = num_src_p'({r_buf_v, r_buf_v} >> r_rr_ptr);
        w_off = '0;
        for (int j = num_src_p - 1; j >= 0; j--)
            if (w_rot[j]) w_off = id_w_lp'(j);
        w_sum   = {1'b0, r_rr_ptr} + {1'b0, w_off};
        w_grant = r_lock ? r_locked_id : (w_sum >= n_lp) ? id_w_lp'(w_sum - n_lp) : w_sum[id_w_lp-1:0];
        w_v     = |r_buf_v;
        w_yumi  = io.late_wb_yumi_i & w_v;
        for (int i = 0; i < num_src_p; i++) begin
            w_drain[i] = w_yumi & (w_grant == id_w_lp'(i));
            w_ready[i] = ~r_buf_v[i] | w_drain[i];
        end
        w_load = io.src_v_i & w_ready;
    end

    assign io.src_ready_and_o = w_ready;
    assign io.late_wb_v_o     = w_v;
    assign io.busy_o          = w_v;
    assign io.grant_id_o      = w_grant;
    assign io.late_wb_pkt_o   = w_v ? r_buf_pkt[w_grant] : '0;
    assign io.late_wb_force_o = w_v & ((r_wait_cnt == lim_lp) | (&r_buf_v));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_buf_v     <= '0;
            r_rr_ptr    <= '0;
            r_lock      <= 1'b0;
            r_locked_id <= '0;
            r_wait_cnt  <= '0;
        end else begin
            r_buf_v <= (r_buf_v & ~w_drain) | w_load;
            r_lock  <= w_v & ~w_yumi;
            if (w_v & ~w_yumi) r_locked_id <= w_grant;
            if (w_yumi) r_rr_ptr <= (w_grant == last_lp) ? '0 : w_grant + 1'b1;
            r_wait_cnt <= (!w_v || w_yumi) ? '0 : (r_wait_cnt == lim_lp) ? r_wait_cnt : r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < num_src_p; i++)
            if (w_load[i]) r_buf_pkt[i] <= io.src_pkt_i[i*pkt_width_p +: pkt_width_p];
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i) assert (!(io.late_wb_yumi_i && !w_v));
    end

`ifdef BP_BE_LATE_WB_STATS_EN
    logic [cnt_width_p-1:0] r_stat_wb, r_stat_force;
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_stat_wb    <= '0;
            r_stat_force <= '0;
        end else begin
            if (w_yumi) r_stat_wb <= r_stat_wb + 1'b1;
            if (w_yumi & io.late_wb_force_o) r_stat_force <= r_stat_force + 1'b1;
        end
    end
    assign io.stat_wb_cnt_o    = r_stat_wb;
    assign io.stat_force_cnt_o = r_stat_force;
`else
    assign io.stat_wb_cnt_o    = {cnt_width_p{1'b0}};
    assign io.stat_force_cnt_o = {cnt_width_p{1'b0}};
`endif
endmodule

// File: tb/tb_bp_be_late_wb_arbiter.sv
// tb_bp_be_late_wb_arbiter: directed + random stimulus against a queue-style reference model.
module tb_bp_be_late_wb_arbiter;
    localparam int N = 3, W = 80, LIM = 16, CW = 16;
    logic clk = 1'b0, rst_n = 1'b1;
    always #5 clk = ~clk;

    bp_be_late_wb_arbiter_if #(.num_src_p(N), .pkt_width_p(W), .cnt_width_p(CW)) bus ();
    bp_be_late_wb_arbiter #(.num_src_p(N), .pkt_width_p(W), .starve_limit_p(LIM), .cnt_width_p(CW)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .io(bus));

    int n_chk = 0, n_err = 0;
    bit         m_v   [N];
    logic [W-1:0] m_pkt [N];
    int m_rr, m_held, m_wait, m_wb, m_force;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_v[i] = 0;
        m_rr = 0; m_held = -1; m_wait = 0; m_wb = 0; m_force = 0;
    endtask

    task automatic chk_stats();
`ifdef BP_BE_LATE_WB_STATS_EN
        chk("stat_wb", W'(bus.stat_wb_cnt_o), W'(m_wb % (1 << CW)));
        chk("stat_force", W'(bus.stat_force_cnt_o), W'(m_force % (1 << CW)));
`else
        chk("stat_wb", W'(bus.stat_wb_cnt_o), '0);
        chk("stat_force", W'(bus.stat_force_cnt_o), '0);
`endif
    endtask

    task automatic chk_reset();
        chk("rst_ready", W'(bus.src_ready_and_o), W'(3'b111));
        chk("rst_v", W'(bus.late_wb_v_o), '0);
        chk("rst_force", W'(bus.late_wb_force_o), '0);
        chk("rst_busy", W'(bus.busy_o), '0);
        chk("rst_grant", W'(bus.grant_id_o), '0);
        chk("rst_pkt", bus.late_wb_pkt_o, '0);
        chk_stats();
    endtask

    // One clock: the scheduler yumis when it wants to or when force is expected.
    task automatic cyc(input logic [N-1:0] sv, input bit want);
        logic [W-1:0] p [N];
        logic [N-1:0] er;
        bit any, full, frc, yv;
        int g;
        any = 0; full = 1;
        for (int i = 0; i < N; i++) begin any |= m_v[i]; full &= m_v[i]; end
        g = m_held;
        if (g < 0) begin
            g = 0;
            for (int k = N - 1; k >= 0; k--) if (m_v[(m_rr + k) % N]) g = (m_rr + k) % N;
        end
        frc = any && (m_wait == LIM || full);
        yv  = any && (want || frc);
        for (int i = 0; i < N; i++) begin
            p[i] = W'({$urandom, $urandom, $urandom});
            bus.src_pkt_i[i*W +: W] = p[i];
            er[i] = !m_v[i] || (yv && g == i);
        end
        bus.src_v_i = sv;
        bus.late_wb_yumi_i = yv;
        @(negedge clk);
        chk("v", W'(bus.late_wb_v_o), W'(any));
        chk("busy", W'(bus.busy_o), W'(any));
        chk("force", W'(bus.late_wb_force_o), W'(frc));
        chk("ready", W'(bus.src_ready_and_o), W'(er));
        if (any) begin
            chk("grant", W'(bus.grant_id_o), W'(g));
            chk("pkt", bus.late_wb_pkt_o, m_pkt[g]);
        end
        chk_stats();
        if (yv) begin
            m_v[g] = 0; m_rr = (g + 1) % N; m_held = -1; m_wait = 0; m_wb++;
            if (frc) m_force++;
        end else if (any) begin
            m_held = g; m_wait = (m_wait < LIM) ? m_wait + 1 : LIM;
        end else m_wait = 0;
        for (int i = 0; i < N; i++)
            if (sv[i] && er[i]) begin m_v[i] = 1; m_pkt[i] = p[i]; end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.src_v_i = '0; bus.late_wb_yumi_i = 1'b0; bus.src_pkt_i = '0;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_reset();
        rst_n = 1'b1;
        repeat (2) cyc(3'b000, 0);
        cyc(3'b111, 1);
        repeat (4) cyc(3'b000, 1);
        repeat (4) cyc(3'b010, 1);
        repeat (2) cyc(3'b000, 1);
        cyc(3'b100, 0);
        repeat (5) cyc(3'b001, 0);
        repeat (3) cyc(3'b000, 1);
        cyc(3'b010, 0);
        repeat (20) cyc(3'b000, 0);
        cyc(3'b000, 1);
        cyc(3'b111, 0);
        repeat (3) cyc(3'b111, 0);
        repeat (4) cyc(3'b000, 1);
        // Asynchronous reset in the middle of traffic, checked before any clock edge.
        cyc(3'b111, 0);
        cyc(3'b011, 0);
        bus.src_v_i = '0; bus.late_wb_yumi_i = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset();
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) cyc(3'b000, 0);
        for (int n = 0; n < 400; n++) cyc(N'($urandom), 1'($urandom));
        repeat (6) cyc(3'b000, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
